// File: rtl/grey_window_meter.sv
// Purpose: decode a cascaded grey counter pair, accumulate count advance over a programmable window, flag illegal steps.
// Latency: i_start sampled at edge N, accumulation on edges N+1..N+W, o_valid high after edge N+W.
// Backpressure: result held in DONE with o_valid until i_ack; i_start ignored outside IDLE.
module grey_window_meter #(
    parameter int pWIDTH   = 5,
    parameter int pWIN_MAX = 11
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [pWIDTH-1:0] i_cnt_a,
    input  logic [pWIDTH-1:0] i_cnt_b,
    input  logic              i_start,
    input  logic [3:0]        i_win,
    input  logic              i_ack,
    output logic              o_busy,
    output logic              o_valid,
    output logic [15:0]       o_delta,
    output logic              o_err
);

    localparam int CW  = 2 * pWIDTH;     // combined binary count width
    localparam int WCW = pWIN_MAX + 4;   // window counter width

    localparam logic [CW-1:0]  LP_STEP_ONE = 1;
    localparam logic [WCW-1:0] LP_WCNT_ONE = 1;
    localparam logic [3:0]     LP_WIN_MAX  = pWIN_MAX[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [pWIDTH-1:0] r_a;
    logic [pWIDTH-1:0] r_b;
    logic [CW-1:0]     r_prev;
    logic [15:0]       r_acc;
    logic              r_err;
    logic [WCW-1:0]    r_wcnt;
    logic [15:0]       r_delta;
    logic              r_oerr;

    logic [CW-1:0]  w_cur;
    logic [CW-1:0]  w_step;
    logic           w_legal;
    logic           w_inc;
    logic [15:0]    w_acc_nxt;
    logic           w_err_nxt;
    logic           w_wdone;
    logic [3:0]     w_wsel;
    logic [4:0]     w_shamt;
    logic [WCW-1:0] w_wload;
    logic           w_busy;
    logic           w_valid;

    // Grey to binary: each binary bit is the xor of all grey bits at or above it.
    function automatic logic [pWIDTH-1:0] g2b(input logic [pWIDTH-1:0] g);
        logic [pWIDTH-1:0] b;
        b[pWIDTH-1] = g[pWIDTH-1];
        for (int k = pWIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    assign w_cur  = {g2b(r_b), g2b(r_a)};
    // Modulo subtraction makes the 1023->0 wrap a step of 1.
    assign w_step = w_cur - r_prev;

    // Only 0 or 1 are legal, so the increment is just the step's lsb when legal.
    assign w_legal   = (w_step <= LP_STEP_ONE);
    assign w_inc     = w_legal & w_step[0];
    assign w_acc_nxt = r_acc + {{15{1'b0}}, w_inc};
    assign w_err_nxt = r_err | ~w_legal;
    assign w_wdone   = (r_wcnt == '0);

    // W-1 = 2^(code+4)-1 is a mask of low ones; avoids a wider W intermediate.
    assign w_wsel  = (i_win > LP_WIN_MAX) ? LP_WIN_MAX : i_win;
    assign w_shamt = {1'b0, w_wsel} + 5'd4;
    assign w_wload = ~({WCW{1'b1}} << w_shamt);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start only from IDLE, leave RUN on the last window cycle, leave DONE on ack.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_wdone) w_state_nxt = S_DONE;
            S_DONE:  if (i_ack)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        w_busy  = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Input capture and step history run every cycle so prev is always one sample behind cur.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prev <= '0;
        end else begin
            r_a    <= i_cnt_a;
            r_b    <= i_cnt_b;
            r_prev <= w_cur;
        end
    end

    // Window accumulation; result registers load only on the final RUN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_wcnt  <= '0;
            r_delta <= '0;
            r_oerr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc  <= '0;
                        r_err  <= 1'b0;
                        r_wcnt <= w_wload;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_err <= w_err_nxt;
                    if (!w_wdone) begin
                        r_wcnt <= r_wcnt - LP_WCNT_ONE;
                    end else begin
                        r_delta <= w_acc_nxt;
                        r_oerr  <= w_err_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = w_busy;
    assign o_valid = w_valid;
    assign o_delta = r_delta;
    assign o_err   = r_oerr;

endmodule

// File: doc/grey_window_meter.md
Name: grey_window_meter

Overview:
- Consumer stage that sits directly downstream of one cascaded pair of grey counters (low stage a, high stage b, 5 bits each).
- Converts the pair to a 10-bit binary count and accumulates the count advance over a programmable window of i_clk cycles.
- Checks grey-count integrity on every cycle.
- Presents the per-window edge total (ring-oscillator frequency relative to i_clk) through a valid/ack handshake, for the output mux or a host.

Parameters:
pWIDTH, 5, bits per grey stage; combined count width is 2*pWIDTH.
pWIN_MAX, 11, maximum legal i_win code; window counter width is pWIN_MAX+4 bits.

Ports:
i_clk    input   1        single clock; all state on rising edge
i_rst    input   1        asynchronous, active-high reset
i_cnt_a  input   pWIDTH   grey-coded low stage count
i_cnt_b  input   pWIDTH   grey-coded high stage count (advances when stage a wraps)
i_start  input   1        start one measurement; sampled in IDLE only
i_win    input   4        window code; W = 16 << min(i_win, pWIN_MAX) cycles; captured on accept
i_ack    input   1        consumer acknowledge of the result
o_busy   output  1        high in RUN and DONE
o_valid  output  1        result valid; high in DONE only
o_delta  output  16       accumulated count advance over the window
o_err    output  1        one or more illegal steps seen in the window

Behaviour:
- Reset (async, i_rst=1): state=IDLE; o_busy=0, o_valid=0, o_delta=0, o_err=0; input regs, prev, acc and window counter all cleared.
  - Reset asserted mid-RUN or in DONE aborts immediately; no result is produced.
- Input path:
  - i_cnt_a and i_cnt_b are registered once into r_a and r_b.
  - Each field is grey-to-binary converted: bin[msb]=g[msb]; bin[k]=bin[k+1]^g[k].
  - cur = {bin(r_b), bin(r_a)}, 10 bits.
- Step tracking (every cycle, all states):
  - step = (cur - prev) mod 1024.
  - prev <= cur.
- Step classification:
  - step in {0,1}: legal.
  - step in 2..1023: illegal.
  - Wrap 1023->0 gives step=1 and is legal.
- FSM states: IDLE, RUN, DONE.
  - IDLE: o_busy=0.
    - i_start=1: capture W, acc<=0, err<=0, wcnt<=W-1, go to RUN next cycle.
  - RUN: every cycle acc<=acc+step if legal, acc<=acc if illegal; an illegal step sets err.
    - wcnt!=0: wcnt decrements.
    - wcnt==0: that cycle's step is still accumulated, then go to DONE.
    - RUN lasts exactly W cycles.
    - i_start and i_ack are ignored in RUN.
  - DONE: o_valid=1; o_delta=acc and o_err=err, both stable until i_ack.
    - i_ack=1: go to IDLE; o_valid drops next cycle.
    - i_start in the same cycle as i_ack is ignored and must be reasserted in IDLE.
- Latency: i_start sampled at edge N -> first accumulation at edge N+1 -> o_valid high after edge N+W.
- Outputs o_delta and o_err:
  - Registered; they hold their last value in IDLE after ack.
  - They update only on the DONE transition.
- Width rules:
  - Legal steps are at most 1 per cycle and W is at most 32768, so acc is at most 32768 and fits 16 bits.
  - No saturation logic is required.
- i_win > pWIN_MAX clamps to pWIN_MAX.

Test Plan:
- Reset: assert i_rst asynchronously mid-cycle -> all outputs 0 immediately; pulse i_start while i_rst=1 -> stays IDLE.
- Static count: hold a=b=grey(0), i_win=0, pulse i_start -> o_valid after 16 cycles; o_delta=0, o_err=0; i_ack -> o_valid=0 next cycle.
- Counting: drive a proper grey sequence advancing every other cycle; cases:
  - i_win=2 -> o_delta=32, o_err=0.
  - Advancing every cycle with i_win=0 -> o_delta=16.
- Wrap: start the count at 1015, advance every cycle, i_win=0 -> crosses 1023->0 inside the window; o_delta=16, o_err=0.
- Integrity: inject one jump of +3 mid-window, other steps +1, i_win=0 -> o_delta=15, o_err=1; next window clean -> o_err=0.
- Handshake/clamp:
  - i_win=15 -> window of 32768 cycles.
  - i_start during RUN -> ignored.
  - Hold i_ack low 5 cycles in DONE -> o_delta stable.
  - i_start with i_ack in the same cycle -> returns to IDLE, no new run.
